br_checkpoint_stack: RTL
========================

# br_checkpoint_stack

Parametrised branch-checkpoint stack for the out-of-order core. It snapshots the rename map (tags and ready bits), ROB tail, SQ tail and freelist head at every branch dispatch. It keeps snapshot ready bits current from N_CDB broadcast channels and tracks branch age with an explicit age matrix. On a mispredict it squashes the resolving branch and all younger checkpoints, then returns the restored state one cycle later. Compared with the previous recovery block it adds configurable depth and CDB width, full back-pressure, out-of-order branch resolution, and registered recovery outputs.

## Interface
- N_CKPT, 4: checkpoint slots (power of 2, ≥2); CW = $clog2(N_CKPT)
- N_ARCH, 32: architectural registers
- PREG_W, 6: physical tag width
- ROB_W, 5 / SQ_W, 3 / FL_W, 6: ROB tail, SQ tail, freelist head pointer widths
- N_CDB, 2: CDB broadcast channels

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low
- ckpt_req  in  1  branch dispatched this cycle; take snapshot
- map_tag_in  in  N_ARCH*PREG_W  current map tags
- map_ready_in  in  N_ARCH  current ready bits
- rob_tail_in / sq_tail_in / fl_head_in  in  ROB_W / SQ_W / FL_W  pointers to save
- ckpt_gnt  out  1  snapshot accepted this cycle
- ckpt_id  out  CW  slot allocated (valid with ckpt_gnt)
- ckpt_bmask  out  N_CKPT  branch mask for the new branch (live_mask | onehot(ckpt_id))
- ckpt_full  out  1  all slots live
- live_mask  out  N_CKPT  registered live slots
- cdb_valid  in  N_CDB  per-channel valid
- cdb_tag  in  N_CDB*PREG_W  broadcast tags
- resolve_valid  in  1  branch resolved
- resolve_id  in  CW  resolving slot
- resolve_mispredict  in  1  1 = mispredict, 0 = correct
- rec_valid  out  1  one-cycle pulse; restored state valid
- rec_map_tag / rec_map_ready  out  N_ARCH*PREG_W / N_ARCH  restored map
- rec_rob_tail / rec_sq_tail / rec_fl_head  out  ROB_W / SQ_W / FL_W  restored pointers
- squash_mask  out  N_CKPT  slots killed (valid with rec_valid)
- clear_mask  out  N_CKPT  one-hot slot correctly resolved (one-cycle pulse)

## Operation
- State per slot: live bit, map tags, ready bits, three pointers, age row older[k][N_CKPT] (older[k][j]=1 means j is older than k).
- Allocation: ckpt_gnt = ckpt_req & !ckpt_full & !(resolve_valid & resolve_mispredict & live[resolve_id]).
  - The slot is the lowest-index non-live slot.
  - On grant: write the snapshot, set live[k], set older[k] = live_mask, clear column k in every row.
- Snapshot ready bits are map_ready_in | (tag match against any valid CDB channel this cycle), i.e. a same-cycle bypass.
- CDB update: every live slot, every arch reg whose stored tag equals a valid cdb_tag sets its ready bit. Duplicate tags across channels are harmless. The ready update does not apply to non-live slots.
- Correct resolve (resolve_valid & !resolve_mispredict & live[r]):
  - clear live[r] and column r of every row;
  - register clear_mask = onehot(r).
- Mispredict (resolve_valid & resolve_mispredict & live[r]):
  - S = onehot(r) | {j : live[j] & older[j][r]};
  - clear live for all of S;
  - register squash_mask = S, rec_valid = 1;
  - register rec_* = slot r contents, with ready bits including this cycle's CDB matches.
- resolve_valid on a non-live slot is ignored; no outputs change.
- A correct resolve freeing the only free slot in the same cycle as ckpt_req does not grant; ckpt_full uses the registered live state only.
- Slots freed this cycle are allocatable next cycle.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): live_mask=0, older=0, ckpt_full=0, ckpt_gnt=0, rec_valid=0, squash_mask=0, clear_mask=0, all rec_* = 0. Slot contents are cleared.
- Reset asserted mid-recovery drops a pending rec_valid immediately.
- ckpt_gnt, ckpt_id, ckpt_bmask, ckpt_full are combinational from registered state and current inputs.
- The snapshot becomes visible at the next rising edge.
- Resolve to rec_valid/clear_mask: exactly 1 cycle. rec_valid and clear_mask are single-cycle pulses.
- Back-to-back resolves on consecutive cycles are supported. Each cycle accepts one resolve.

## Test plan
- Reset, then 4 ckpt_req on consecutive cycles.
  - Required: ids 0,1,2,3, bmasks 0001,0011,0111,1111.
  - 5th request: ckpt_gnt=0, ckpt_full=1.
- Snapshot slot 0 with map reg 5 tag 12, not ready. Next cycle cdb_valid=01, cdb_tag[0]=12. Then mispredict on slot 0.
  - Required: rec_valid 1 cycle later, rec_map_ready[5]=1.
- Allocate 0,1,2. Correct-resolve 1, then allocate again.
  - Required: clear_mask=0010, new id=1, ckpt_bmask=0111.
  - Mispredict 0 → squash_mask=0111, live_mask=0000.
- Allocate 0,1,2. Mispredict 1 with a simultaneous ckpt_req.
  - Required: ckpt_gnt=0, squash_mask=0110, rec_rob_tail = value saved at slot 1, live_mask=0001.
- Snapshot in the same cycle as a CDB tag matching map_tag_in[3], with map_ready_in[3]=0.
  - Required: a later mispredict on that slot restores ready[3]=1.
- Assert reset the cycle after a mispredict.
  - Required: rec_valid drops to 0 immediately, live_mask=0.
- resolve_valid on a free slot.
  - Required: no output change.

Source files
------------

// File: rtl/br_checkpoint_stack.sv
`default_nettype none
// ============================================================================
//  Module      : br_checkpoint_stack
//  Description : Branch checkpoint stack. It snapshots the rename map and the
//                ROB/SQ/freelist pointers at dispatch, keeps snapshot ready
//                bits current from the CDB, and restores state on mispredict.
//  Revision    : 1.0 - initial release
// ============================================================================
module br_checkpoint_stack #(
    parameter int  N_CKPT = 4,
    parameter int  N_ARCH = 32,
    parameter int  PREG_W = 6,
    parameter int  ROB_W  = 5,
    parameter int  SQ_W   = 3,
    parameter int  FL_W   = 6,
    parameter int  N_CDB  = 2,
    localparam int CW     = $clog2(N_CKPT)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     ckpt_req,
    input  logic [N_ARCH*PREG_W-1:0] map_tag_in,
    input  logic [N_ARCH-1:0]        map_ready_in,
    input  logic [ROB_W-1:0]         rob_tail_in,
    input  logic [SQ_W-1:0]          sq_tail_in,
    input  logic [FL_W-1:0]          fl_head_in,
    output logic                     ckpt_gnt,
    output logic [CW-1:0]            ckpt_id,
    output logic [N_CKPT-1:0]        ckpt_bmask,
    output logic                     ckpt_full,
    output logic [N_CKPT-1:0]        live_mask,
    input  logic [N_CDB-1:0]         cdb_valid,
    input  logic [N_CDB*PREG_W-1:0]  cdb_tag,
    input  logic                     resolve_valid,
    input  logic [CW-1:0]            resolve_id,
    input  logic                     resolve_mispredict,
    output logic                     rec_valid,
    output logic [N_ARCH*PREG_W-1:0] rec_map_tag,
    output logic [N_ARCH-1:0]        rec_map_ready,
    output logic [ROB_W-1:0]         rec_rob_tail,
    output logic [SQ_W-1:0]          rec_sq_tail,
    output logic [FL_W-1:0]          rec_fl_head,
    output logic [N_CKPT-1:0]        squash_mask,
    output logic [N_CKPT-1:0]        clear_mask
);

    localparam logic [N_CKPT-1:0] c_one = {{(N_CKPT-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Slot storage
    // ------------------------------------------------------------------
    logic [N_CKPT-1:0]        r_live;
    logic [N_CKPT-1:0]        r_older [N_CKPT];
    logic [N_ARCH*PREG_W-1:0] r_tag   [N_CKPT];
    logic [N_ARCH-1:0]        r_ready [N_CKPT];
    logic [ROB_W-1:0]         r_rob   [N_CKPT];
    logic [SQ_W-1:0]          r_sq    [N_CKPT];
    logic [FL_W-1:0]          r_fl    [N_CKPT];

    // Registered recovery outputs
    logic                     r_rec_valid;
    logic [N_ARCH*PREG_W-1:0] r_rec_tag;
    logic [N_ARCH-1:0]        r_rec_ready;
    logic [ROB_W-1:0]         r_rec_rob;
    logic [SQ_W-1:0]          r_rec_sq;
    logic [FL_W-1:0]          r_rec_fl;
    logic [N_CKPT-1:0]        r_squash;
    logic [N_CKPT-1:0]        r_clear;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [N_ARCH-1:0] w_in_hit;
    logic [N_ARCH-1:0] w_slot_hit [N_CKPT];
    logic              w_res_live;
    logic              w_mispred;
    logic              w_correct;
    logic [N_CKPT-1:0] w_res_onehot;
    logic [N_CKPT-1:0] w_squash;
    logic [N_CKPT-1:0] w_col_clr;
    logic [CW-1:0]     w_alloc_id;
    logic [N_CKPT-1:0] w_alloc_onehot;
    logic              w_full;
    logic              w_gnt;
    logic [N_CKPT-1:0] w_live_nxt;

    // CDB matches against the incoming map (snapshot bypass) and every slot
    always_comb begin
        w_in_hit = '0;
        for (int k = 0; k < N_CKPT; k++) begin
            w_slot_hit[k] = '0;
        end
        for (int a = 0; a < N_ARCH; a++) begin
            for (int c = 0; c < N_CDB; c++) begin
                if (cdb_valid[c] &&
                    (cdb_tag[c*PREG_W +: PREG_W] == map_tag_in[a*PREG_W +: PREG_W])) begin
                    w_in_hit[a] = 1'b1;
                end
                for (int k = 0; k < N_CKPT; k++) begin
                    if (cdb_valid[c] &&
                        (cdb_tag[c*PREG_W +: PREG_W] == r_tag[k][a*PREG_W +: PREG_W])) begin
                        w_slot_hit[k][a] = 1'b1;
                    end
                end
            end
        end
    end

    assign w_res_live   = resolve_valid & r_live[resolve_id];
    assign w_mispred    = w_res_live & resolve_mispredict;
    assign w_correct    = w_res_live & ~resolve_mispredict;
    assign w_res_onehot = c_one << resolve_id;

    // Squash set: the resolving branch plus every live branch younger than it
    always_comb begin
        w_squash = w_res_onehot;
        for (int j = 0; j < N_CKPT; j++) begin
            if (r_live[j] && r_older[j][resolve_id]) begin
                w_squash[j] = 1'b1;
            end
        end
    end

    always_comb begin
        w_col_clr = '0;
        if (w_mispred) begin
            w_col_clr = w_squash;
        end else if (w_correct) begin
            w_col_clr = w_res_onehot;
        end
    end

    // Lowest-index free slot
    always_comb begin
        w_alloc_id = '0;
        for (int i = N_CKPT - 1; i >= 0; i--) begin
            if (!r_live[i]) begin
                w_alloc_id = CW'(i);
            end
        end
    end

    assign w_alloc_onehot = c_one << w_alloc_id;
    assign w_full         = &r_live;
    assign w_gnt          = ckpt_req & ~w_full & ~w_mispred;

    always_comb begin
        w_live_nxt = r_live;
        if (w_gnt) begin
            w_live_nxt = w_live_nxt | w_alloc_onehot;
        end
        if (w_mispred) begin
            w_live_nxt = w_live_nxt & ~w_squash;
        end else if (w_correct) begin
            w_live_nxt = w_live_nxt & ~w_res_onehot;
        end
    end

    // ------------------------------------------------------------------
    // Slot state
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_live <= '0;
            for (int k = 0; k < N_CKPT; k++) begin
                r_older[k] <= '0;
                r_tag[k]   <= '0;
                r_ready[k] <= '0;
                r_rob[k]   <= '0;
                r_sq[k]    <= '0;
                r_fl[k]    <= '0;
            end
        end else begin
            r_live <= w_live_nxt;
            for (int k = 0; k < N_CKPT; k++) begin
                if (w_gnt && (w_alloc_id == CW'(k))) begin
                    // Resolved columns are masked so the new row never names a freed slot
                    r_older[k] <= r_live & ~w_col_clr;
                    r_tag[k]   <= map_tag_in;
                    r_ready[k] <= map_ready_in | w_in_hit;
                    r_rob[k]   <= rob_tail_in;
                    r_sq[k]    <= sq_tail_in;
                    r_fl[k]    <= fl_head_in;
                end else begin
                    r_older[k] <= r_older[k] & ~w_col_clr;
                    if (r_live[k]) begin
                        r_ready[k] <= r_ready[k] | w_slot_hit[k];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Recovery / clear outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rec_valid <= 1'b0;
            r_rec_tag   <= '0;
            r_rec_ready <= '0;
            r_rec_rob   <= '0;
            r_rec_sq    <= '0;
            r_rec_fl    <= '0;
            r_squash    <= '0;
            r_clear     <= '0;
        end else begin
            r_rec_valid <= w_mispred;
            r_squash    <= w_mispred ? w_squash : '0;
            r_clear     <= w_correct ? w_res_onehot : '0;
            if (w_mispred) begin
                r_rec_tag   <= r_tag[resolve_id];
                r_rec_ready <= r_ready[resolve_id] | w_slot_hit[resolve_id];
                r_rec_rob   <= r_rob[resolve_id];
                r_rec_sq    <= r_sq[resolve_id];
                r_rec_fl    <= r_fl[resolve_id];
            end
        end
    end

    assign ckpt_gnt      = w_gnt;
    assign ckpt_id       = w_alloc_id;
    assign ckpt_bmask    = r_live | w_alloc_onehot;
    assign ckpt_full     = w_full;
    assign live_mask     = r_live;
    assign rec_valid     = r_rec_valid;
    assign rec_map_tag   = r_rec_tag;
    assign rec_map_ready = r_rec_ready;
    assign rec_rob_tail  = r_rec_rob;
    assign rec_sq_tail   = r_rec_sq;
    assign rec_fl_head   = r_rec_fl;
    assign squash_mask   = r_squash;
    assign clear_mask    = r_clear;

endmodule
`default_nettype wire
